// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcodes, state encoding and datapath select codes for control_unit_ws
package cu_pkg;

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_AND_AB  = 8'h44;
    localparam logic [7:0] OP_OR_AB   = 8'h45;
    localparam logic [7:0] OP_INCA    = 8'h46;
    localparam logic [7:0] OP_INCB    = 8'h47;
    localparam logic [7:0] OP_DECA    = 8'h48;
    localparam logic [7:0] OP_DECB    = 8'h49;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BMI     = 8'h21;
    localparam logic [7:0] OP_BPL     = 8'h22;
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_BNE     = 8'h24;
    localparam logic [7:0] OP_BVS     = 8'h25;
    localparam logic [7:0] OP_BVC     = 8'h26;
    localparam logic [7:0] OP_BCS     = 8'h27;
    localparam logic [7:0] OP_BCC     = 8'h28;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_F0   = 4'd1;
    localparam logic [3:0] S_F1   = 4'd2;
    localparam logic [3:0] S_F2   = 4'd3;
    localparam logic [3:0] S_D3   = 4'd4;
    localparam logic [3:0] S_E4   = 4'd5;
    localparam logic [3:0] S_E5   = 4'd6;
    localparam logic [3:0] S_E6   = 4'd7;
    localparam logic [3:0] S_E7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    typedef enum logic [2:0] {
        CLS_LD_IMM,
        CLS_LD_DIR,
        CLS_ST_DIR,
        CLS_ALU2,
        CLS_ALU1,
        CLS_BRANCH,
        CLS_ILLEGAL
    } iclass_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_INC = 3'b100;
    localparam logic [2:0] ALU_DEC = 3'b101;

    localparam logic [1:0] BUS1_PC   = 2'b00;
    localparam logic [1:0] BUS1_A    = 2'b01;
    localparam logic [1:0] BUS1_B    = 2'b10;
    localparam logic [1:0] BUS2_ALU  = 2'b00;
    localparam logic [1:0] BUS2_BUS1 = 2'b01;
    localparam logic [1:0] BUS2_MEM  = 2'b10;

    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

endpackage

// File: rtl/cu_opcode_decode.sv
// rtl/cu_opcode_decode.sv - combinational opcode classifier and branch-condition evaluator
module cu_opcode_decode
    import cu_pkg::*;
(
    input  logic [7:0] ir,
    input  logic [3:0] ccr,
    output iclass_t    iclass,
    output logic       tgt_b,
    output logic [2:0] alu_sel,
    output logic       br_taken
);

    always_comb begin
        iclass   = CLS_ILLEGAL;
        tgt_b    = 1'b0;
        alu_sel  = ALU_ADD;
        br_taken = 1'b0;
        case (ir)
            OP_LDA_IMM: iclass = CLS_LD_IMM;
            OP_LDB_IMM: begin iclass = CLS_LD_IMM; tgt_b = 1'b1; end
            OP_LDA_DIR: iclass = CLS_LD_DIR;
            OP_LDB_DIR: begin iclass = CLS_LD_DIR; tgt_b = 1'b1; end
            OP_STA_DIR: iclass = CLS_ST_DIR;
            OP_STB_DIR: begin iclass = CLS_ST_DIR; tgt_b = 1'b1; end
            OP_ADD_AB:  begin iclass = CLS_ALU2; alu_sel = ALU_ADD; end
            OP_SUB_AB:  begin iclass = CLS_ALU2; alu_sel = ALU_SUB; end
            OP_AND_AB:  begin iclass = CLS_ALU2; alu_sel = ALU_AND; end
            OP_OR_AB:   begin iclass = CLS_ALU2; alu_sel = ALU_OR;  end
            OP_INCA:    begin iclass = CLS_ALU1; alu_sel = ALU_INC; end
            OP_INCB:    begin iclass = CLS_ALU1; alu_sel = ALU_INC; tgt_b = 1'b1; end
            OP_DECA:    begin iclass = CLS_ALU1; alu_sel = ALU_DEC; end
            OP_DECB:    begin iclass = CLS_ALU1; alu_sel = ALU_DEC; tgt_b = 1'b1; end
            OP_BRA:     begin iclass = CLS_BRANCH; br_taken = 1'b1; end
            OP_BMI:     begin iclass = CLS_BRANCH; br_taken = ccr[CCR_N]; end
            OP_BPL:     begin iclass = CLS_BRANCH; br_taken = ~ccr[CCR_N]; end
            OP_BEQ:     begin iclass = CLS_BRANCH; br_taken = ccr[CCR_Z]; end
            OP_BNE:     begin iclass = CLS_BRANCH; br_taken = ~ccr[CCR_Z]; end
            OP_BVS:     begin iclass = CLS_BRANCH; br_taken = ccr[CCR_V]; end
            OP_BVC:     begin iclass = CLS_BRANCH; br_taken = ~ccr[CCR_V]; end
            OP_BCS:     begin iclass = CLS_BRANCH; br_taken = ccr[CCR_C]; end
            OP_BCC:     begin iclass = CLS_BRANCH; br_taken = ~ccr[CCR_C]; end
            default:    iclass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit_ws.sv
// rtl/control_unit_ws.sv - Moore fetch/decode/execute sequencer with memory wait states
module control_unit_ws
    import cu_pkg::*;
#(
    parameter bit WAIT_EN         = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    input  logic       mem_ready,
    output logic [2:0] ALU_Sel,
    output logic [1:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic       CCR_Load,
    output logic       write,
    output logic       halted
);

    logic [3:0] state_q, state_d;
    iclass_t    cls_q, cls_d;
    logic       tgt_b_q, tgt_b_d;
    logic [2:0] alu_q, alu_d;
    logic       taken_q, taken_d;

    iclass_t    dec_cls;
    logic       dec_tgt_b;
    logic [2:0] dec_alu;
    logic       dec_taken;

    logic       stall;
    logic       rd_state;
    logic       ir_ld, mar_ld, pc_ld, pc_inc, a_ld, b_ld, ccr_ld;
    logic [1:0] tgt_bus1;

    cu_opcode_decode u_decode (
        .ir       (IR),
        .ccr      (CCR_Result),
        .iclass   (dec_cls),
        .tgt_b    (dec_tgt_b),
        .alu_sel  (dec_alu),
        .br_taken (dec_taken)
    );

    assign stall    = WAIT_EN & ~mem_ready;
    assign tgt_bus1 = tgt_b_q ? BUS1_B : BUS1_A;

    // Decode results are captured in D3 so execute states never look at IR or CCR_Result.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        tgt_b_d = tgt_b_q;
        alu_d   = alu_q;
        taken_d = taken_q;
        case (state_q)
            S_IDLE: state_d = S_F0;
            S_F0:   state_d = S_F1;
            S_F1:   state_d = S_F2;
            S_F2:   if (!stall) state_d = S_D3;
            S_D3: begin
                cls_d   = dec_cls;
                tgt_b_d = dec_tgt_b;
                alu_d   = dec_alu;
                taken_d = dec_taken;
                if (dec_cls == CLS_ILLEGAL)
                    state_d = HALT_ON_ILLEGAL ? S_HALT : S_F0;
                else
                    state_d = S_E4;
            end
            S_E4: begin
                case (cls_q)
                    CLS_LD_IMM, CLS_LD_DIR, CLS_ST_DIR: state_d = S_E5;
                    CLS_BRANCH: state_d = taken_q ? S_E5 : S_F0;
                    default:    state_d = S_F0;
                endcase
            end
            S_E5: begin
                if (cls_q == CLS_BRANCH) begin
                    if (!stall) state_d = S_F0;
                end else begin
                    state_d = S_E6;
                end
            end
            S_E6:   if (!stall) state_d = (cls_q == CLS_LD_IMM) ? S_F0 : S_E7;
            S_E7:   if (!stall) state_d = S_F0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ALU_Sel  = ALU_ADD;
        Bus1_Sel = BUS1_PC;
        Bus2_Sel = BUS2_ALU;
        write    = 1'b0;
        halted   = 1'b0;
        rd_state = 1'b0;
        ir_ld    = 1'b0;
        mar_ld   = 1'b0;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        a_ld     = 1'b0;
        b_ld     = 1'b0;
        ccr_ld   = 1'b0;
        case (state_q)
            S_F0: begin Bus1_Sel = BUS1_PC; Bus2_Sel = BUS2_BUS1; mar_ld = 1'b1; end
            S_F1: pc_inc = 1'b1;
            S_F2: begin Bus2_Sel = BUS2_MEM; ir_ld = 1'b1; rd_state = 1'b1; end
            S_E4: begin
                case (cls_q)
                    CLS_ALU2: begin
                        Bus1_Sel = BUS1_B;
                        ALU_Sel  = alu_q;
                        a_ld     = 1'b1;
                        ccr_ld   = 1'b1;
                    end
                    CLS_ALU1: begin
                        Bus1_Sel = tgt_bus1;
                        ALU_Sel  = alu_q;
                        a_ld     = ~tgt_b_q;
                        b_ld     = tgt_b_q;
                        ccr_ld   = 1'b1;
                    end
                    CLS_BRANCH: begin
                        if (taken_q) begin
                            Bus2_Sel = BUS2_BUS1;
                            mar_ld   = 1'b1;
                        end else begin
                            pc_inc = 1'b1;
                        end
                    end
                    default: begin Bus2_Sel = BUS2_BUS1; mar_ld = 1'b1; end
                endcase
            end
            S_E5: begin
                if (cls_q == CLS_BRANCH) begin
                    Bus2_Sel = BUS2_MEM;
                    pc_ld    = 1'b1;
                    rd_state = 1'b1;
                end else begin
                    pc_inc = 1'b1;
                end
            end
            S_E6: begin
                Bus2_Sel = BUS2_MEM;
                rd_state = 1'b1;
                if (cls_q == CLS_LD_IMM) begin
                    a_ld = ~tgt_b_q;
                    b_ld = tgt_b_q;
                end else begin
                    mar_ld = 1'b1;
                end
            end
            S_E7: begin
                if (cls_q == CLS_ST_DIR) begin
                    Bus1_Sel = tgt_bus1;
                    write    = 1'b1;
                end else begin
                    Bus2_Sel = BUS2_MEM;
                    rd_state = 1'b1;
                    a_ld     = ~tgt_b_q;
                    b_ld     = tgt_b_q;
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    // A read waiting on memory keeps its selects but must not commit anything.
    assign IR_Load  = ir_ld  & ~(rd_state & stall);
    assign MAR_Load = mar_ld & ~(rd_state & stall);
    assign PC_Load  = pc_ld  & ~(rd_state & stall);
    assign PC_Inc   = pc_inc & ~(rd_state & stall);
    assign A_Load   = a_ld   & ~(rd_state & stall);
    assign B_Load   = b_ld   & ~(rd_state & stall);
    assign CCR_Load = ccr_ld & ~(rd_state & stall);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cls_q   <= CLS_ILLEGAL;
            tgt_b_q <= 1'b0;
            alu_q   <= ALU_ADD;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            tgt_b_q <= tgt_b_d;
            alu_q   <= alu_d;
            taken_q <= taken_d;
        end
    end

endmodule

// File: tb/tb_control_unit_ws.sv
// tb/tb_control_unit_ws.sv - scoreboard bench for control_unit_ws across three parameter sets
module tb_control_unit_ws;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic       mem_ready;

    logic [2:0] alu0, alu1, alu2;
    logic [1:0] b1s0, b1s1, b1s2, b2s0, b2s1, b2s2;
    logic [8:0] stb0, stb1, stb2;

    always #5 clk = ~clk;

    control_unit_ws #(.WAIT_EN(1'b1), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .IR(IR), .CCR_Result(CCR_Result), .mem_ready(mem_ready),
        .ALU_Sel(alu0), .Bus1_Sel(b1s0), .Bus2_Sel(b2s0),
        .IR_Load(stb0[0]), .MAR_Load(stb0[1]), .PC_Load(stb0[2]), .PC_Inc(stb0[3]),
        .A_Load(stb0[4]), .B_Load(stb0[5]), .CCR_Load(stb0[6]), .write(stb0[7]), .halted(stb0[8])
    );

    control_unit_ws #(.WAIT_EN(1'b1), .HALT_ON_ILLEGAL(1'b0)) dut_nohalt (
        .clk(clk), .reset(reset), .IR(IR), .CCR_Result(CCR_Result), .mem_ready(mem_ready),
        .ALU_Sel(alu1), .Bus1_Sel(b1s1), .Bus2_Sel(b2s1),
        .IR_Load(stb1[0]), .MAR_Load(stb1[1]), .PC_Load(stb1[2]), .PC_Inc(stb1[3]),
        .A_Load(stb1[4]), .B_Load(stb1[5]), .CCR_Load(stb1[6]), .write(stb1[7]), .halted(stb1[8])
    );

    control_unit_ws #(.WAIT_EN(1'b0), .HALT_ON_ILLEGAL(1'b1)) dut_nowait (
        .clk(clk), .reset(reset), .IR(IR), .CCR_Result(CCR_Result), .mem_ready(mem_ready),
        .ALU_Sel(alu2), .Bus1_Sel(b1s2), .Bus2_Sel(b2s2),
        .IR_Load(stb2[0]), .MAR_Load(stb2[1]), .PC_Load(stb2[2]), .PC_Inc(stb2[3]),
        .A_Load(stb2[4]), .B_Load(stb2[5]), .CCR_Load(stb2[6]), .write(stb2[7]), .halted(stb2[8])
    );

    // Strobe bits: {halted, write, CCR_Load, B_Load, A_Load, PC_Inc, PC_Load, MAR_Load, IR_Load}
    localparam logic [8:0] ST_IRL = 9'h001;
    localparam logic [8:0] ST_MAR = 9'h002;
    localparam logic [8:0] ST_PCL = 9'h004;
    localparam logic [8:0] ST_PCI = 9'h008;
    localparam logic [8:0] ST_AL  = 9'h010;
    localparam logic [8:0] ST_BL  = 9'h020;
    localparam logic [8:0] ST_CCR = 9'h040;
    localparam logic [8:0] ST_WR  = 9'h080;
    localparam logic [8:0] ST_HLT = 9'h100;

    function automatic logic [15:0] mk(input logic [2:0] alu, input logic [1:0] b1,
                                       input logic [1:0] b2, input logic [8:0] st);
        return {st, b2, b1, alu};
    endfunction

    logic [15:0] exp_q[$];
    int          id_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    logic [15:0] v_idle, v_f0, v_f1, v_f2, v_d3, v_e4m, v_e6dir, v_halt;

    task automatic push(input int id, input logic [15:0] e, input string name);
        exp_q.push_back(e);
        id_q.push_back(id);
        name_q.push_back(name);
    endtask

    task automatic cyc(input int id, input logic [15:0] e, input string name, input logic mr);
        @(posedge clk);
        #1;
        mem_ready = mr;
        push(id, e, name);
    endtask

    task automatic fetch(input int id, input logic mr);
        cyc(id, v_f0, "F0", mr);
        cyc(id, v_f1, "F1", mr);
        cyc(id, v_f2, "F2", mr);
        cyc(id, v_d3, "D3", mr);
    endtask

    task automatic do_reset(input int id);
        @(posedge clk);
        #2;
        reset = 1'b0;
        push(id, v_idle, "reset_idle");
        @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin : monitor
        logic [15:0] e, act;
        int          id;
        string       name;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                id   = id_q.pop_front();
                name = name_q.pop_front();
                case (id)
                    0:       act = {stb0, b2s0, b1s0, alu0};
                    1:       act = {stb1, b2s1, b1s1, alu1};
                    default: act = {stb2, b2s2, b1s2, alu2};
                endcase
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s (dut %0d): got st=%b b2=%b b1=%b alu=%b, expected st=%b b2=%b b1=%b alu=%b",
                             name, id, act[15:7], act[6:5], act[4:3], act[2:0],
                             e[15:7], e[6:5], e[4:3], e[2:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : stim
        v_idle  = 16'h0000;
        v_f0    = mk(3'b000, 2'b00, 2'b01, ST_MAR);
        v_f1    = mk(3'b000, 2'b00, 2'b00, ST_PCI);
        v_f2    = mk(3'b000, 2'b00, 2'b10, ST_IRL);
        v_d3    = 16'h0000;
        v_e4m   = mk(3'b000, 2'b00, 2'b01, ST_MAR);
        v_e6dir = mk(3'b000, 2'b00, 2'b10, ST_MAR);
        v_halt  = mk(3'b000, 2'b00, 2'b00, ST_HLT);

        reset      = 1'b0;
        IR         = 8'h86;
        CCR_Result = 4'b0000;
        mem_ready  = 1'b1;
        #1;
        push(0, v_idle, "reset_idle");
        #11;
        reset = 1'b1;

        // LDA_IMM: read in E6 lands on cycle 7 after IDLE
        fetch(0, 1'b1);
        cyc(0, v_e4m, "lda_imm_E4", 1'b1);
        cyc(0, v_f1, "lda_imm_E5", 1'b1);
        cyc(0, mk(3'b000, 2'b00, 2'b10, ST_AL), "lda_imm_E6", 1'b1);
        cyc(0, v_f0, "lda_imm_F0", 1'b1);

        // STA_DIR with three wait cycles on the write
        IR = 8'h96;
        do_reset(0);
        fetch(0, 1'b1);
        cyc(0, v_e4m, "sta_E4", 1'b1);
        cyc(0, v_f1, "sta_E5", 1'b1);
        cyc(0, v_e6dir, "sta_E6", 1'b1);
        cyc(0, mk(3'b000, 2'b01, 2'b00, ST_WR), "sta_E7_w1", 1'b0);
        cyc(0, mk(3'b000, 2'b01, 2'b00, ST_WR), "sta_E7_w2", 1'b0);
        cyc(0, mk(3'b000, 2'b01, 2'b00, ST_WR), "sta_E7_w3", 1'b0);
        cyc(0, mk(3'b000, 2'b01, 2'b00, ST_WR), "sta_E7_go", 1'b1);
        cyc(0, v_f0, "sta_F0", 1'b1);

        // STB_DIR interrupted by reset while the write is pending
        IR = 8'h97;
        do_reset(0);
        fetch(0, 1'b1);
        cyc(0, v_e4m, "stb_E4", 1'b1);
        cyc(0, v_f1, "stb_E5", 1'b1);
        cyc(0, v_e6dir, "stb_E6", 1'b1);
        cyc(0, mk(3'b000, 2'b10, 2'b00, ST_WR), "stb_E7_wait", 1'b0);
        do_reset(0);
        cyc(0, v_f0, "after_reset_F0", 1'b1);

        // BNE taken (Z=0) with one wait cycle on the operand read
        IR = 8'h24;
        CCR_Result = 4'b0000;
        do_reset(0);
        fetch(0, 1'b1);
        cyc(0, v_e4m, "bne_tk_E4", 1'b1);
        cyc(0, mk(3'b000, 2'b00, 2'b10, 9'h000), "bne_tk_E5_wait", 1'b0);
        cyc(0, mk(3'b000, 2'b00, 2'b10, ST_PCL), "bne_tk_E5", 1'b1);
        cyc(0, v_f0, "bne_tk_F0", 1'b1);

        // BNE not taken (Z=1)
        CCR_Result = 4'b0100;
        do_reset(0);
        fetch(0, 1'b1);
        cyc(0, v_f1, "bne_nt_E4", 1'b1);
        cyc(0, v_f0, "bne_nt_F0", 1'b1);
        cyc(0, v_f1, "bne_nt_F1", 1'b1);

        // Unary and binary ALU operations
        CCR_Result = 4'b0000;
        IR = 8'h48;
        do_reset(0);
        fetch(0, 1'b1);
        cyc(0, mk(3'b101, 2'b01, 2'b00, ST_AL | ST_CCR), "deca_E4", 1'b1);
        cyc(0, v_f0, "deca_F0", 1'b1);
        IR = 8'h47;
        do_reset(0);
        fetch(0, 1'b1);
        cyc(0, mk(3'b100, 2'b10, 2'b00, ST_BL | ST_CCR), "incb_E4", 1'b1);
        cyc(0, v_f0, "incb_F0", 1'b1);
        IR = 8'h43;
        do_reset(0);
        fetch(0, 1'b1);
        cyc(0, mk(3'b001, 2'b10, 2'b00, ST_AL | ST_CCR), "sub_E4", 1'b1);
        cyc(0, v_f0, "sub_F0", 1'b1);

        // Illegal opcode, halting variant
        IR = 8'hFF;
        do_reset(0);
        fetch(0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(0, v_halt, "halt_hold", 1'b1);
        do_reset(0);
        cyc(0, v_f0, "halt_reset_F0", 1'b1);

        // Illegal opcode, NOP variant
        do_reset(1);
        fetch(1, 1'b1);
        cyc(1, v_f0, "nop_F0", 1'b1);
        cyc(1, v_f1, "nop_F1", 1'b1);

        // WAIT_EN=0: LDA_DIR completes in 8 cycles despite mem_ready low
        IR = 8'h87;
        mem_ready = 1'b0;
        do_reset(2);
        fetch(2, 1'b0);
        cyc(2, v_e4m, "nw_E4", 1'b0);
        cyc(2, v_f1, "nw_E5", 1'b0);
        cyc(2, v_e6dir, "nw_E6", 1'b0);
        cyc(2, mk(3'b000, 2'b00, 2'b10, ST_AL), "nw_E7", 1'b0);
        cyc(2, v_f0, "nw_F0", 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit_ws.md
# control_unit_ws

Parametrised successor to the 8-bit computer's control unit. It is a Moore FSM that sequences fetch, decode and execute for the full load/store, ALU and conditional-branch instruction set. It adds a memory-ready wait handshake and selectable illegal-opcode handling. It sits between the instruction register, CCR and memory on one side and the datapath load/select strobes on the other.

## Interface
- WAIT_EN, 1: 1 = memory-access states stall until `mem_ready`; 0 = `mem_ready` ignored, fixed one cycle per access.
- HALT_ON_ILLEGAL, 1: 1 = an undefined opcode halts the unit; 0 = an undefined opcode executes as a NOP.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- IR  in  8  current opcode.
- CCR_Result  in  4  flags {N,Z,V,C}; bit3=N, bit2=Z, bit1=V, bit0=C.
- mem_ready  in  1  memory access complete this cycle.
- ALU_Sel  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 INC, 101 DEC.
- Bus1_Sel  out  2  Bus1 source: 00 PC, 01 A, 10 B.
- Bus2_Sel  out  2  Bus2 source: 00 ALU, 01 Bus1, 10 memory.
- IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load  out  1 each  datapath strobes.
- write  out  1  memory write request.
- halted  out  1  unit stopped on an illegal opcode.

## Operation
- Reset: the FSM enters IDLE, where every output is 0. IDLE always moves to F0 on the next clock.
- Fetch sequence:
  - F0: Bus1=PC, Bus2=Bus1, MAR_Load.
  - F1: PC_Inc.
  - F2: Bus2=mem, IR_Load (memory read).
  - D3: decode only, no strobes.
- Load immediate, LDA_IMM 86 / LDB_IMM 88:
  - E4: MAR<=PC.
  - E5: PC_Inc.
  - E6: Bus2=mem, A_Load or B_Load (read).
- Load direct, LDA_DIR 87 / LDB_DIR 89:
  - E4, E5 as for immediate.
  - E6: Bus2=mem, MAR_Load (read).
  - E7: Bus2=mem, A_Load or B_Load (read).
- Store direct, STA_DIR 96 / STB_DIR 97:
  - E4, E5, E6 as for load direct.
  - E7: Bus1=A or B, write.
- Two-operand ALU ops, ADD_AB 42 / SUB_AB 43 / AND_AB 44 / OR_AB 45:
  - E4: Bus1=B, Bus2=ALU, ALU_Sel per op, A_Load, CCR_Load.
- Unary ALU ops, INCA 46 / INCB 47 / DECA 48 / DECB 49:
  - E4: Bus1=target register, Bus2=ALU, INC or DEC, target register load, CCR_Load.
- Branches are BRA 20, BMI 21 (N=1), BPL 22 (N=0), BEQ 23 (Z=1), BNE 24 (Z=0), BVS 25 (V=1), BVC 26 (V=0), BCS 27 (C=1), BCC 28 (C=0).
  - Condition is sampled in D3.
  - Taken: E4 MAR<=PC; E5 Bus2=mem, PC_Load (read).
  - Not taken: E4 PC_Inc to skip the operand.
- Every execute sequence returns to F0.
- Illegal opcode:
  - HALT_ON_ILLEGAL=1: D3 goes to HALT; `halted`=1 and all strobes are 0 until reset.
  - HALT_ON_ILLEGAL=0: D3 goes straight back to F0.
- Wait handshake, WAIT_EN=1:
  - Read state with `mem_ready`=0: the state is held, bus selects and ALU_Sel stay driven, and every load/inc strobe is forced to 0. Strobes assert only in the cycle where `mem_ready`=1.
  - Write state: `write` stays 1 until `mem_ready`=1, then the FSM advances.

## Timing
- All outputs are decoded from the registered state only; nothing depends combinationally on IR, CCR_Result or mem_ready.
- Exception: the strobe gating in read states does depend on `mem_ready`.
- Cycle counts with zero wait states, including the 4-cycle fetch/decode:
  - LD/ST immediate: 7.
  - LD/ST direct: 8.
  - ALU op: 5.
  - Branch taken: 6; branch not taken: 5.
- Each cycle of `mem_ready`=0 in a read or write state adds exactly 1 cycle.
- IR is sampled in D3 and must be stable from F2 onward; CCR_Result is sampled in D3 only.
- Reset asserted mid-instruction: the FSM goes to IDLE immediately and all outputs drop to 0 asynchronously, including a pending `write`.
- HALT is exited only by reset.

## Structure
- Shared package `cu_pkg` holds:
  - opcode localparams;
  - state encoding (IDLE, F0–F2, D3, E4–E7, HALT);
  - ALU_Sel and Bus1/Bus2 select codes;
  - CCR bit indices.
- Sub-module `cu_opcode_decode` is combinational. It maps IR to an instruction class (LD_IMM, LD_DIR, ST_DIR, ALU2, ALU1, BRANCH, ILLEGAL), a target register and an ALU_Sel value.
- It also evaluates the branch condition from CCR_Result.

## Test plan
- Reset low for 12 ns, then release; IR=86, mem_ready=1.
  - Outputs are 0 in IDLE; F0 shows MAR_Load=1, Bus2_Sel=01.
  - A_Load=1 with Bus2_Sel=10 in cycle 7 after IDLE, then back to F0.
- STA_DIR (96) with mem_ready low for 3 cycles in E7.
  - `write`=1 for 4 cycles with Bus1_Sel=01, then F0.
- BNE (24), CCR_Result=0000: PC_Load=1 in E5. Same with CCR_Result=0100: only PC_Inc in E4, and PC_Load never asserts.
- DECA (48): in E4, ALU_Sel=101, Bus1_Sel=01, Bus2_Sel=00, A_Load=1, CCR_Load=1, all for exactly one cycle.
- IR=FF:
  - HALT_ON_ILLEGAL=1: `halted`=1 and all strobes stay 0 for 20 cycles; reset clears `halted`.
  - HALT_ON_ILLEGAL=0: F0 follows D3.
- WAIT_EN=0 with mem_ready held 0: LDA_DIR (87) still completes in 8 cycles.
